// File: rtl/hb_wb_master_pkg.sv
// Shared types and default constants for the hostbus-to-Wishbone master.
package hb_wb_master_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int          DEF_TIMEOUT  = 255;
  localparam logic [15:0] DEF_ERR_DATA = 16'hDEAD;

endpackage

// File: rtl/hb_wb_master_if.sv
// Host request/response and global Wishbone signals bundled for the master.
interface hb_wb_master_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  hb_req;
  logic                  hb_write;
  logic [ADDR_WIDTH-1:0] hb_addr;
  logic [DATA_WIDTH-1:0] hb_wrData;
  logic [DATA_WIDTH-1:0] hb_rdData;
  logic                  hb_done;
  logic                  hb_err;
  logic                  hb_busy;
  logic                  glob_cycle;
  logic                  glob_strobe;
  logic                  glob_write;
  logic                  glob_ack;
  logic [ADDR_WIDTH-1:0] glob_addr;
  logic [DATA_WIDTH-1:0] glob_wrData;
  logic [DATA_WIDTH-1:0] glob_rdData;

  modport master (
    input  hb_req, hb_write, hb_addr, hb_wrData, glob_ack, glob_rdData,
    output hb_rdData, hb_done, hb_err, hb_busy,
           glob_cycle, glob_strobe, glob_write, glob_addr, glob_wrData
  );

  modport slave (
    output hb_req, hb_write, hb_addr, hb_wrData, glob_ack, glob_rdData,
    input  hb_rdData, hb_done, hb_err, hb_busy,
           glob_cycle, glob_strobe, glob_write, glob_addr, glob_wrData
  );
endinterface

// File: rtl/hb_wb_master_timeout.sv
// Ack-timeout counter: cleared on accept, counts unacked WAIT cycles.
module hb_wb_master_timeout
  import hb_wb_master_pkg::*;
#(
  parameter int TO_WIDTH = 8,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [TO_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + TO_WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign expire_o = (count_q == TO_WIDTH'(TIMEOUT - 1));
endmodule

// File: rtl/hb_wb_master.sv
// Turns each host request edge into exactly one classic Wishbone cycle,
// with a per-transfer ack timeout so unmapped addresses cannot hang the host.
//   state   | meaning
//   ST_IDLE | no transfer; waiting for a rising edge on hb_req
//   ST_WAIT | cyc/stb asserted, waiting for ack or timeout
module hb_wb_master
  import hb_wb_master_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    TO_WIDTH   = 8,
  parameter int                    TIMEOUT    = DEF_TIMEOUT,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DEF_ERR_DATA
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  hb_wb_master_if.master bus
);
  state_e                state_q, state_d;
  logic                  req_q;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  req_edge;
  logic                  to_clr, to_en, to_expire;

  assign req_edge = bus.hb_req & ~req_q;

  hb_wb_master_timeout #(
    .TO_WIDTH (TO_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (to_clr),
    .en_i     (to_en),
    .expire_o (to_expire)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    to_clr  = 1'b0;
    to_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          state_d = ST_WAIT;
          we_d    = bus.hb_write;
          addr_d  = bus.hb_addr;
          wdata_d = bus.hb_wrData;
          to_clr  = 1'b1;
        end
      end
      ST_WAIT: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (bus.glob_ack) begin
          state_d = ST_IDLE;
          we_d    = 1'b0;
          done_d  = 1'b1;
          if (!we_q) rdata_d = bus.glob_rdData;
        end else if (to_expire) begin
          state_d = ST_IDLE;
          we_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end else begin
          to_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= bus.hb_req;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // cyc/stb/busy come straight from the state flop so reset drops them at once.
  assign bus.glob_cycle  = (state_q == ST_WAIT);
  assign bus.glob_strobe = (state_q == ST_WAIT);
  assign bus.hb_busy     = (state_q == ST_WAIT);
  assign bus.glob_write  = we_q;
  assign bus.glob_addr   = addr_q;
  assign bus.glob_wrData = wdata_q;
  assign bus.hb_rdData   = rdata_q;
  assign bus.hb_done     = done_q;
  assign bus.hb_err      = err_q;
endmodule
